// File: rtl/rr_arb8_ctrl_if.sv
// Request/grant bundle between the 8 requesters and the round-robin arbiter.
// The arbiter connects through the slave modport; the requester side (or a
// bench) connects through the master modport.
interface rr_arb8_ctrl_if;
  logic [7:0] i_req;
  logic [7:0] o_gnt;
  logic [2:0] o_gnt_bin;
  logic       o_gnt_valid;
  logic       o_preempt;

  modport master (
    output i_req,
    input  o_gnt,
    input  o_gnt_bin,
    input  o_gnt_valid,
    input  o_preempt
  );

  modport slave (
    input  i_req,
    output o_gnt,
    output o_gnt_bin,
    output o_gnt_valid,
    output o_preempt
  );
endinterface

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters sharing one resource.
// The owner keeps the grant while it requests; a hold-limit timer forces
// rotation when the owner has held MAX_HOLD cycles and someone else waits.
// o_gnt is registered; o_gnt_bin / o_gnt_valid are decoded from it only.
module rr_arb8_ctrl #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rr_arb8_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_nxt;
  logic [7:0]        gnt, gnt_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic              preempt, preempt_nxt;

  logic [7:0]        search_req;
  logic [2:0]        win;
  logic              found;
  logic [2:0]        idx;
  logic              owner_req;

  // Round-robin search: first set bit of search_req from ptr upward, mod 8.
  // While BUSY the current owner is masked out so a release or preemption
  // always moves the grant to a different requester.
  always_comb begin
    search_req = (state == BUSY) ? (bus.i_req & ~gnt) : bus.i_req;
    win        = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && search_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state, grant, pointer, hold counter and preempt pulse.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    preempt_nxt = 1'b0;
    owner_req   = |(bus.i_req & gnt);

    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          gnt_nxt   = 8'(1) << win;
          ptr_nxt   = win + 3'd1;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          // Release wins over a coinciding hold expiry: no preempt pulse.
          cnt_nxt = '0;
          if (found) begin
            gnt_nxt = 8'(1) << win;
            ptr_nxt = win + 3'd1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if ((MAX_HOLD != 0) && (cnt >= HOLD_LAST) && found) begin
          // ">=" so an owner parked at the saturated count still yields
          // as soon as a competitor appears.
          gnt_nxt     = 8'(1) << win;
          ptr_nxt     = win + 3'd1;
          cnt_nxt     = '0;
          preempt_nxt = 1'b1;
        end else if (cnt < HOLD_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      preempt <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      preempt <= preempt_nxt;
    end
  end

  // Output decode from the registered grant only, one-hot encoder style.
  always_comb begin
    bus.o_gnt          = gnt;
    bus.o_gnt_bin[0]   = gnt[1] | gnt[3] | gnt[5] | gnt[7];
    bus.o_gnt_bin[1]   = gnt[2] | gnt[3] | gnt[6] | gnt[7];
    bus.o_gnt_bin[2]   = gnt[4] | gnt[5] | gnt[6] | gnt[7];
    bus.o_gnt_valid    = |gnt;
    bus.o_preempt      = preempt;
  end

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge i_clk) $onehot0(gnt));
  a_preempt_has_gnt: assert property (@(posedge i_clk) preempt |-> (|gnt));
`endif

endmodule
